// File: rtl/timer_tick_sched.sv
// Avalon-MM master for a 16-bit interval timer: configures it, services its irq, and
// divides each serviced tick into per-channel sticky event requests with overrun tracking.
module timer_tick_sched #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NUM_CH*DIV_W-1:0] ch_div,
  input  logic [NUM_CH-1:0]       ch_ack,
  input  logic                    clr_err,
  output logic [2:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic [15:0]             tmr_readdata,
  input  logic                    tmr_irq,
  output logic                    tick_pulse,
  output logic [31:0]             tick_count,
  output logic [NUM_CH-1:0]       ch_req,
  output logic [NUM_CH-1:0]       ch_overrun,
  output logic                    cfg_err,
  output logic                    busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_STOP, S_CLR, S_START, S_RDREQ, S_RDCAP, S_RUN, S_ACK, S_HALT
  } state_t;

  state_t                          r_state;
  state_t                          w_next;
  logic [31:0]                     r_tick_count;
  logic [NUM_CH-1:0][DIV_W-1:0]    r_cnt;
  logic [NUM_CH-1:0][DIV_W-1:0]    w_cnt_next;
  logic [NUM_CH-1:0][DIV_W-1:0]    w_div;
  logic [NUM_CH-1:0]               r_req;
  logic [NUM_CH-1:0]               r_ovr;
  logic [NUM_CH-1:0]               w_ev;
  logic [NUM_CH-1:0]               w_req_next;
  logic [NUM_CH-1:0]               w_ovr_next;
  logic                            r_cfg_err;
  logic                            w_rd_bad;
  logic                            w_unused;

  assign w_div    = ch_div;
  assign w_rd_bad = (r_state == S_RDCAP) && (tmr_readdata[3:0] != 4'h3);
  assign w_unused = ^tmr_readdata[15:4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Bus outputs are decoded from state so every access occupies exactly one cycle.
  always_comb begin
    w_next         = r_state;
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0000;
    case (r_state)
      S_IDLE:  if (enable) w_next = S_STOP;
      S_STOP:  begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd1; tmr_writedata = 16'h0008;
        w_next = S_CLR;
      end
      S_CLR:   begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        w_next = S_START;
      end
      S_START: begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd1; tmr_writedata = 16'h0007;
        w_next = S_RDREQ;
      end
      S_RDREQ: begin
        tmr_chipselect = 1'b1; tmr_address = 3'd1;
        w_next = S_RDCAP;
      end
      S_RDCAP: w_next = w_rd_bad ? S_HALT : S_RUN;
      S_RUN:   begin
        if (!enable)      w_next = S_HALT;
        else if (tmr_irq) w_next = S_ACK;
      end
      S_ACK:   begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0;
        w_next = S_RUN;
      end
      S_HALT:  begin
        tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd1; tmr_writedata = 16'h0008;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ">=" rather than "==" so a divisor lowered below the running count fires next tick.
  always_comb begin
    w_cnt_next = r_cnt;
    w_ev       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_state == S_CLR) begin
        w_cnt_next[i] = '0;
      end else if (r_state == S_ACK) begin
        if (w_div[i] == '0) begin
          w_cnt_next[i] = '0;
        end else if (r_cnt[i] >= w_div[i] - DIV_W'(1)) begin
          w_ev[i]       = 1'b1;
          w_cnt_next[i] = '0;
        end else begin
          w_cnt_next[i] = r_cnt[i] + DIV_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_req_next = r_req;
    w_ovr_next = r_ovr;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clr_err)                   w_ovr_next[i] = 1'b0;
      if (ch_ack[i])                 w_req_next[i] = 1'b0;
      if (w_ev[i])                   w_req_next[i] = 1'b1;
      if (w_ev[i] && r_req[i] && !ch_ack[i]) w_ovr_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick_count <= 32'd0;
      r_cnt        <= '0;
      r_req        <= '0;
      r_ovr        <= '0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_req <= w_req_next;
      r_ovr <= w_ovr_next;
      if (r_state == S_CLR)      r_tick_count <= 32'd0;
      else if (r_state == S_ACK) r_tick_count <= r_tick_count + 32'd1;
      if (w_rd_bad)     r_cfg_err <= 1'b1;
      else if (clr_err) r_cfg_err <= 1'b0;
    end
  end

  assign tick_pulse = (r_state == S_ACK);
  assign tick_count = r_tick_count;
  assign ch_req     = r_req;
  assign ch_overrun = r_ovr;
  assign cfg_err    = r_cfg_err;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_timer_tick_sched.sv
// Bench for timer_tick_sched: timer slave stand-in, tick-indexed reference model, directed scenarios.
module tb_timer_tick_sched;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int P_IDLE = 0, P_STOP = 1, P_CLR = 2, P_START = 3, P_RDREQ = 4,
                 P_RDCAP = 5, P_RUN = 6, P_ACK = 7, P_HALT = 8;

  logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, clr_err = 1'b0, tmr_irq = 1'b0;
  logic bad_rd = 1'b0, preset = 1'b0;
  logic [NUM_CH*DIV_W-1:0] ch_div = '0;
  logic [NUM_CH-1:0] ch_ack = '0;
  logic [2:0] tmr_address;
  logic tmr_chipselect, tmr_write_n, tick_pulse, cfg_err, busy;
  logic [15:0] tmr_writedata, tmr_readdata;
  logic [31:0] tick_count;
  logic [NUM_CH-1:0] ch_req, ch_overrun;
  logic [1:0] tmr_ctrl;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  timer_tick_sched #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ch_div(ch_div), .ch_ack(ch_ack),
    .clr_err(clr_err), .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata),
    .tmr_irq(tmr_irq), .tick_pulse(tick_pulse), .tick_count(tick_count), .ch_req(ch_req),
    .ch_overrun(ch_overrun), .cfg_err(cfg_err), .busy(busy)
  );

  // Timer slave: stores control bits [1:0] (bits 2/3 are strobes), reads them back.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) tmr_ctrl <= 2'b00;
    else if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd1) tmr_ctrl <= tmr_writedata[1:0];
  end
  assign tmr_readdata = bad_rd ? 16'h0000 : {14'h0000, tmr_ctrl};

  // Reference model: channel events come from tick index modulo divisor.
  int m_ph = P_IDLE;
  int m_ticks = 0;
  logic [31:0] m_tick = 32'd0;
  logic [NUM_CH-1:0] m_req = '0, m_ovr = '0;
  logic m_err = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = P_IDLE; m_ticks = 0; m_tick = 32'd0; m_req = '0; m_ovr = '0; m_err = 1'b0;
    end else begin : mdl
      int d;
      bit ev;
      for (int i = 0; i < NUM_CH; i++) begin
        d  = int'(ch_div[i*DIV_W +: DIV_W]);
        ev = (m_ph == P_ACK) && (d != 0) && (((m_ticks + 1) % d) == 0);
        m_ovr[i] = (ev && m_req[i] && !ch_ack[i]) ? 1'b1 : (clr_err ? 1'b0 : m_ovr[i]);
        m_req[i] = ev ? 1'b1 : (ch_ack[i] ? 1'b0 : m_req[i]);
      end
      if (m_ph == P_RDCAP && tmr_readdata[3:0] != 4'h3) m_err = 1'b1;
      else if (clr_err) m_err = 1'b0;
      if (m_ph == P_CLR) begin m_tick = 32'd0; m_ticks = 0; end
      else if (m_ph == P_ACK) begin m_tick = m_tick + 32'd1; m_ticks = m_ticks + 1; end
      if (preset) m_tick = 32'hFFFF_FFFF;
      case (m_ph)
        P_IDLE:  if (enable) m_ph = P_STOP;
        P_RDCAP: m_ph = (tmr_readdata[3:0] == 4'h3) ? P_RUN : P_HALT;
        P_RUN:   if (!enable) m_ph = P_HALT; else if (tmr_irq) m_ph = P_ACK;
        P_ACK:   m_ph = P_RUN;
        P_HALT:  m_ph = P_IDLE;
        default: m_ph = m_ph + 1;
      endcase
    end
  end

  function automatic logic [20:0] exp_bus(int ph);
    case (ph)
      P_STOP, P_HALT: return {1'b1, 1'b0, 3'd1, 16'h0008};
      P_CLR, P_ACK:   return {1'b1, 1'b0, 3'd0, 16'h0000};
      P_START:        return {1'b1, 1'b0, 3'd1, 16'h0007};
      P_RDREQ:        return {1'b1, 1'b1, 3'd1, 16'h0000};
      default:        return {1'b0, 1'b1, 3'd0, 16'h0000};
    endcase
  endfunction

  function automatic logic [20:0] bus_now();
    return {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("bus", 32'(bus_now()), 32'(exp_bus(m_ph)));
    chk("tick_pulse", 32'(tick_pulse), 32'(m_ph == P_ACK));
    chk("busy", 32'(busy), 32'(m_ph != P_IDLE));
    chk("tick_count", tick_count, m_tick);
    chk("ch_req", 32'(ch_req), 32'(m_req));
    chk("ch_overrun", 32'(ch_overrun), 32'(m_ovr));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_div(input int d0, input int d1, input int d2, input int d3);
    ch_div = {DIV_W'(d3), DIV_W'(d2), DIV_W'(d1), DIV_W'(d0)};
  endtask

  task automatic start_run();
    enable = 1'b1;
    repeat (6) step();
  endtask

  task automatic do_irq(input bit drop_en);
    bit seen = 1'b0;
    tmr_irq = 1'b1;
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) begin
        seen = 1'b1;
        tmr_irq = 1'b0;
        if (drop_en) enable = 1'b0;
      end
    end
    tmr_irq = 1'b0;
    chk("irq_serviced", 32'(seen), 32'd1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    compare_all();
    chk("rst_write_n", 32'(tmr_write_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    step();

    // Startup sequence with hand-written bus cycles, then divide-by-{0,1,3,2}.
    set_div(0, 1, 3, 2);
    enable = 1'b1;
    step(); chk("t1_stop",  32'(bus_now()), 32'({1'b1, 1'b0, 3'd1, 16'h0008}));
    step(); chk("t1_clr",   32'(bus_now()), 32'({1'b1, 1'b0, 3'd0, 16'h0000}));
    step(); chk("t1_start", 32'(bus_now()), 32'({1'b1, 1'b0, 3'd1, 16'h0007}));
    step(); chk("t1_read",  32'(bus_now()), 32'({1'b1, 1'b1, 3'd1, 16'h0000}));
    step(); step();
    chk("t1_run_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      do_irq(1'b0);
      if (k == 5) chk("t2_req_tick5", 32'(ch_req), 32'h2);
      if (k == 6) chk("t2_req_tick6", 32'(ch_req), 32'hE);
      ch_ack = 4'hF; step(); ch_ack = 4'h0;
    end
    chk("t2_tick_count", tick_count, 32'd6);
    chk("t2_no_overrun", 32'(ch_overrun), 32'd0);

    // Overrun on ch3 after two unacked events, then ack + clear.
    enable = 1'b0; repeat (3) step();
    chk("t3_idle", 32'(busy), 32'd0);
    set_div(0, 0, 0, 2);
    start_run();
    repeat (4) do_irq(1'b0);
    chk("t3_req", 32'(ch_req), 32'h8);
    chk("t3_overrun", 32'(ch_overrun), 32'h8);
    ch_ack = 4'h8; clr_err = 1'b1; step(); ch_ack = 4'h0; clr_err = 1'b0;
    chk("t3_req_clr", 32'(ch_req), 32'h0);
    chk("t3_ovr_clr", 32'(ch_overrun), 32'h0);

    // enable dropped in ACK: ACK completes, RUN, HALT, IDLE.
    do_irq(1'b1);
    step(); chk("t5_halt", 32'(bus_now()), 32'({1'b1, 1'b0, 3'd1, 16'h0008}));
    step(); chk("t5_idle", 32'(busy), 32'd0);

    // Bad control readback.
    bad_rd = 1'b1; enable = 1'b1;
    step(); enable = 1'b0;
    repeat (5) step();
    chk("t4_cfg_err", 32'(cfg_err), 32'd1);
    chk("t4_halt", 32'(bus_now()), 32'({1'b1, 1'b0, 3'd1, 16'h0008}));
    step(); chk("t4_idle", 32'(busy), 32'd0);
    bad_rd = 1'b0; clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("t4_err_clr", 32'(cfg_err), 32'd0);

    // tick_count wrap, then reset mid-RUN.
    start_run();
    force dut.r_tick_count = 32'hFFFF_FFFF;
    preset = 1'b1;
    step();
    release dut.r_tick_count;
    preset = 1'b0;
    do_irq(1'b0);
    chk("t6_wrap", tick_count, 32'd0);
    do_irq(1'b0);
    chk("t6_after_wrap", tick_count, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_bus", 32'(bus_now()), 32'({1'b0, 1'b1, 3'd0, 16'h0000}));
    chk("t6_rst_req", 32'(ch_req), 32'd0);
    step();
    reset_n = 1'b1;
    enable = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
